// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low column drive, debounces a single
// key press/release, emits a hex key code strobe and shifts digits into an operand.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] operand
);
    localparam int CMAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    state_t          state_q;
    logic [1:0]      col_idx_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      pat_q;
    logic [3:0]      row_s1_q;
    logic [3:0]      rs_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_held_q;
    logic [31:0]     operand_q;
    logic [31:0]     operand_d;

    function automatic logic one_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!v[i]) idx = 2'(i);
        return idx;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= 4'hF;
            rs_q     <= 4'hF;
        end else begin
            row_s1_q <= row;
            rs_q     <= row_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            cnt_q       <= '0;
            pat_q       <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= '0;
                        if (one_low(rs_q)) begin
                            pat_q   <= rs_q;
                            state_q <= DEBOUNCE;
                        end else begin
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (rs_q != pat_q) begin
                        // bounce: rescan the same column from a fresh dwell
                        state_q <= SCAN;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        key_code_q  <= {low_idx(pat_q), col_idx_q};
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        state_q     <= PRESSED;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (rs_q != 4'hF) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        key_held_q <= 1'b0;
                        col_idx_q  <= col_idx_q + 2'd1;
                        state_q    <= SCAN;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= SCAN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // digit is shifted in while the strobe is visible; clear wins that cycle
    always_comb begin
        operand_d = operand_q;
        if (clear)
            operand_d = 32'h0;
        else if (key_valid_q)
            operand_d = {operand_q[27:0], key_code_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) operand_q <= 32'h0;
        else        operand_q <= operand_d;
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign operand   = operand_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: behavioural keypad matrix, expected-code queue checked
// on every key_valid strobe, plus scan order, debounce, release and reset checks.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic        clear = 1'b0;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] operand;

    logic [15:0] keys = 16'h0;
    logic [3:0]  exp_q[$];
    logic [31:0] exp_op = 32'h0;
    int          total = 0;
    int          bad = 0;
    int          nvalid = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .clear(clear), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .operand(operand)
    );

    // a pressed key pulls its row low only while its column is driven
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            nvalid++;
            if (exp_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else                   chk("key_code", {28'h0, key_code}, {28'h0, exp_q.pop_front()});
        end
    end

    task automatic press_key(input logic [3:0] code, input logic clr_on_valid);
        int n0;
        int t;
        n0 = nvalid;
        exp_q.push_back(code);
        keys = 16'h1 << code;
        t = 0;
        while (nvalid == n0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (nvalid == n0) chk("accept_timeout", 32'd0, 32'd1);
        chk("held_on_accept", {31'h0, key_held}, 32'd1);
        if (clr_on_valid) begin
            clear  = 1'b1;
            exp_op = 32'h0;
        end else begin
            exp_op = {exp_op[27:0], code};
        end
        @(negedge clk);
        clear = 1'b0;
        chk("operand", operand, exp_op);
    endtask

    task automatic release_key();
        int t;
        keys = 16'h0;
        t = 0;
        while (key_held && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("release_held", {31'h0, key_held}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0;
        // 1: reset values and idle column rotation
        repeat (2) @(negedge clk);
        chk("rst_col", {28'h0, col}, 32'he);
        chk("rst_code", {28'h0, key_code}, 32'h0);
        chk("rst_valid", {31'h0, key_valid}, 32'h0);
        chk("rst_held", {31'h0, key_held}, 32'h0);
        chk("rst_operand", operand, 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            chk("scan_col", {28'h0, col}, {28'h0, ~(4'b0001 << ((k / 4) % 4))});
            @(negedge clk);
        end
        chk("idle_no_valid", nvalid, 32'd0);

        // 2: key 6 = row1/col2
        press_key(4'h6, 1'b0);
        chk("operand_6", operand, 32'h6);
        release_key();

        // 3: digit entry and wrap
        clear = 1'b1; exp_op = 32'h0;
        @(negedge clk);
        clear = 1'b0;
        chk("clear", operand, 32'h0);
        press_key(4'h1, 1'b0); release_key();
        press_key(4'h2, 1'b0); release_key();
        press_key(4'h3, 1'b0); release_key();
        chk("operand_123", operand, 32'h123);
        for (int i = 0; i < 9; i++) begin
            press_key(4'hA, 1'b0);
            release_key();
        end
        chk("operand_wrap", operand, 32'hAAAAAAAA);

        // 4: bouncing contact never accepts, then a stable press accepts once
        n0 = nvalid;
        for (int i = 0; i < 20; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0;
            repeat (3) @(negedge clk);
        end
        keys = 16'h0;
        repeat (4) @(negedge clk);
        chk("bounce_no_valid", nvalid - n0, 32'd0);
        n0 = nvalid;
        press_key(4'h5, 1'b0);
        release_key();
        chk("bounce_then_one", nvalid - n0, 32'd1);

        // 5: long hold, release glitch, exact release timing
        n0 = nvalid;
        press_key(4'hC, 1'b0);
        repeat (40) @(negedge clk);
        chk("hold_single", nvalid - n0, 32'd1);
        keys = 16'h0;
        repeat (5) @(negedge clk);
        keys = 16'h1000;
        repeat (6) @(negedge clk);
        chk("glitch_held", {31'h0, key_held}, 32'd1);
        keys = 16'h0;
        repeat (9) @(negedge clk);
        chk("release_pre", {31'h0, key_held}, 32'd1);
        @(negedge clk);
        chk("release_edge", {31'h0, key_held}, 32'd0);
        repeat (4) @(negedge clk);

        // 6: clear in strobe cycle, multi-key reject, reset while pressed
        press_key(4'hF, 1'b1);
        chk("clear_wins", operand, 32'h0);
        release_key();
        n0 = nvalid;
        keys = 16'h0022;
        repeat (100) @(negedge clk);
        chk("multi_no_valid", nvalid - n0, 32'd0);
        chk("multi_not_held", {31'h0, key_held}, 32'd0);
        keys = 16'h0;
        repeat (4) @(negedge clk);
        press_key(4'h9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_held", {31'h0, key_held}, 32'd0);
        chk("arst_code", {28'h0, key_code}, 32'h0);
        chk("arst_operand", operand, 32'h0);
        chk("arst_col", {28'h0, col}, 32'he);
        keys = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        n0 = nvalid;
        repeat (40) @(negedge clk);
        chk("post_rst_no_valid", nvalid - n0, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
